// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional S[i]=i fill, then the KSA swap loop over a
// single-port S RAM with configurable read latency, abort and busy/done status.
module rc4_ksa_engine #(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned INIT_EN   = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   input  logic [8*KEY_BYTES-1:0]             key,
   input  logic [$clog2(KEY_BYTES+1)-1:0]     key_len,
   input  logic [ADDR_W-1:0]                  mem_rdata,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic [ADDR_W-1:0]                  mem_wdata,
   output logic                               mem_wren,
   output logic                               busy,
   output logic                               done
);

   localparam int unsigned KLW = $clog2(KEY_BYTES + 1);
   localparam int unsigned CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [ADDR_W-1:0] IMAX = '1;

   typedef enum logic [3:0] {
      StIdle, StFill, StRdSi, StWtSi, StCalcJ, StRdSj, StWtSj, StWrSi, StWrSj, StDone
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
   logic [KLW-1:0]         k_q, k_d, klen_q, klen_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic [CW-1:0]          wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]      addr_d, wdata_d;
   logic                   wren_d, busy_d, done_d;
   logic [7:0]             kbyte;
   logic                   accept;

   always_comb begin
      kbyte = '0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (k_q == KLW'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      k_d     = k_q;
      klen_d  = klen_q;
      key_d   = key_q;
      wcnt_d  = wcnt_q;
      accept  = start && !abort;

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               key_d   = key;
               klen_d  = (key_len == '0 || key_len > KLW'(KEY_BYTES)) ? KLW'(KEY_BYTES) : key_len;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = (INIT_EN != 0) ? StFill : StRdSi;
            end
         end
         StFill: begin
            i_d = i_q + ADDR_W'(1);
            if (i_q == IMAX) state_d = StRdSi;
         end
         StRdSi: begin
            wcnt_d  = '0;
            state_d = StWtSi;
         end
         StWtSi: begin
            if (wcnt_q == CW'(RD_LAT - 1)) begin
               si_d    = mem_rdata;
               state_d = StCalcJ;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         StCalcJ: begin
            j_d     = j_q + si_q + ADDR_W'(kbyte);
            state_d = StRdSj;
         end
         StRdSj: begin
            wcnt_d  = '0;
            state_d = StWtSj;
         end
         StWtSj: begin
            if (wcnt_q == CW'(RD_LAT - 1)) begin
               sj_d    = mem_rdata;
               state_d = StWrSi;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         StWrSi: state_d = StWrSj;
         StWrSj: begin
            // k follows i mod key_len with a wrap counter instead of a divider
            k_d = (k_q == klen_q - KLW'(1)) ? '0 : k_q + KLW'(1);
            if (i_q == IMAX) begin
               state_d = StDone;
            end else begin
               i_d     = i_q + ADDR_W'(1);
               state_d = StRdSi;
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort) state_d = StIdle;

      // Outputs are registered, so decode them from the state being entered
      addr_d  = '0;
      wdata_d = '0;
      wren_d  = 1'b0;
      unique case (state_d)
         StFill: begin
            addr_d  = i_d;
            wdata_d = i_d;
            wren_d  = 1'b1;
         end
         StRdSi, StWtSi: addr_d = i_d;
         StRdSj, StWtSj: addr_d = j_d;
         StWrSi: begin
            addr_d  = j_d;
            wdata_d = si_d;
            wren_d  = 1'b1;
         end
         StWrSj: begin
            addr_d  = i_d;
            wdata_d = sj_d;
            wren_d  = 1'b1;
         end
         default: ;
      endcase
      busy_d = (state_d != StIdle) && (state_d != StDone);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         i_q       <= '0;
         j_q       <= '0;
         si_q      <= '0;
         sj_q      <= '0;
         k_q       <= '0;
         klen_q    <= '0;
         key_q     <= '0;
         wcnt_q    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wren  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         si_q      <= si_d;
         sj_q      <= sj_d;
         k_q       <= k_d;
         klen_q    <= klen_d;
         key_q     <= key_d;
         wcnt_q    <= wcnt_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         mem_wren  <= wren_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine: cycle-accurate bus trace and final S
// contents compared against a software KSA model, two parameterisations.
module tb_rc4_ksa_engine;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       wren;
      logic       busy;
      logic       done;
   } bus_t;

   logic        clk;
   logic        rst_n, start1, start2, abort, preload2;
   logic [23:0] key;
   logic [1:0]  key_len;
   logic [7:0]  addr1, wdata1, rdata1, addr2, wdata2, rdata2, rd2a;
   logic        wren1, busy1, done1, wren2, busy2, done2;

   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   logic [7:0] ms   [256];
   int         mj   [256];
   logic [7:0] msi  [256];
   bus_t       tq[$], q1[$], q2[$];
   bus_t       e1, e2;
   int         checks = 0;
   int         errors = 0;

   rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_W(8), .RD_LAT(1), .INIT_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .key(key), .key_len(key_len),
      .mem_rdata(rdata1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_wren(wren1),
      .busy(busy1), .done(done1)
   );

   rc4_ksa_engine #(.KEY_BYTES(3), .ADDR_W(8), .RD_LAT(2), .INIT_EN(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .key(key), .key_len(key_len),
      .mem_rdata(rdata2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_wren(wren2),
      .busy(busy2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S RAMs: synchronous read with 1 and 2 cycles of latency, read-old on collision
   always @(posedge clk) begin
      if (wren1) mem1[addr1] <= wdata1;
      rdata1 <= mem1[addr1];
   end

   always @(posedge clk) begin
      if (preload2) begin
         for (int a = 0; a < 256; a++) mem2[a] <= 8'(a);
      end else if (wren2) begin
         mem2[addr2] <= wdata2;
      end
      rd2a   <= mem2[addr2];
      rdata2 <= rd2a;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push(input int a, input int w, input bit we, input bit b, input bit d);
      bus_t t;
      t.addr  = 8'(a);
      t.wdata = 8'(w);
      t.wren  = we;
      t.busy  = b;
      t.done  = d;
      tq.push_back(t);
   endfunction

   // Software KSA producing the expected per-cycle bus trace and final S
   function automatic void build(input logic [23:0] k, input int kl, input int lat, input bit init);
      int   klen, j, kb;
      logic [7:0] si, sj;
      tq.delete();
      klen = (kl == 0 || kl > 3) ? 3 : kl;
      for (int a = 0; a < 256; a++) ms[a] = 8'(a);
      if (init) for (int a = 0; a < 256; a++) push(a, a, 1, 1, 0);
      j = 0;
      for (int i = 0; i < 256; i++) begin
         for (int c = 0; c <= lat; c++) push(i, 0, 0, 1, 0);
         push(0, 0, 0, 1, 0);
         kb = int'((k >> (8 * (2 - (i % klen)))) & 24'hFF);
         j  = (j + int'(ms[i]) + kb) % 256;
         for (int c = 0; c <= lat; c++) push(j, 0, 0, 1, 0);
         si = ms[i];
         sj = ms[j];
         push(j, si, 1, 1, 0);
         push(i, sj, 1, 1, 0);
         ms[j]  = si;
         ms[i]  = sj;
         mj[i]  = j;
         msi[i] = si;
      end
      push(0, 0, 0, 0, 1);
   endfunction

   always @(negedge clk) begin
      if (q1.size() != 0) begin
         e1 = q1.pop_front();
         check("trace1", {13'b0, addr1, wdata1, wren1, busy1, done1}, {13'b0, e1});
      end
      if (q2.size() != 0) begin
         e2 = q2.pop_front();
         check("trace2", {13'b0, addr2, wdata2, wren2, busy2, done2}, {13'b0, e2});
      end
   end

   task automatic launch1(input logic [23:0] k, input logic [1:0] kl);
      key     = k;
      key_len = kl;
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      build(k, int'(kl), 1, 1);
      q1 = tq;
   endtask

   task automatic run1(input logic [23:0] k, input logic [1:0] kl, input bit disturb);
      int cnt;
      launch1(k, kl);
      cnt = 0;
      do begin
         @(posedge clk);
         #1 cnt++;
         if (disturb && cnt == 500) begin
            start1  = 1'b1;
            key     = 24'($urandom);
            key_len = 2'd1;
         end
         if (disturb && cnt == 503) start1 = 1'b0;
      end while (!done1 && cnt < 3000);
      check("latency1", cnt, 2048);
      @(negedge clk);
      for (int a = 0; a < 256; a++) check("s1", mem1[a], ms[a]);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0; preload2 = 1'b0;
      key = '0; key_len = '0;
      #2;
      check("rst_addr", addr1, 0);
      check("rst_wdata", wdata1, 0);
      check("rst_wren", wren1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_busy2", busy2, 0);
      #20 rst_n = 1'b1;

      // Hand-computed first swaps pin the model
      build(24'h000249, 3, 1, 1);
      check("pin_i1_wrsi_addr", tq[256 + 7 + 5].addr, 3);
      check("pin_i1_wrsi_data", tq[256 + 7 + 5].wdata, 1);
      check("pin_i2_wrsi_addr", tq[256 + 14 + 5].addr, 78);
      check("pin_i2_wrsi_data", tq[256 + 14 + 5].wdata, 2);
      check("pin_i3_wrsi_addr", tq[256 + 21 + 5].addr, 79);
      check("pin_i3_wrsj_data", tq[256 + 21 + 6].wdata, 79);
      build(24'h5A0000, 1, 1, 1);
      check("pin_k1_wrsi_addr", tq[256 + 5].addr, 90);
      check("pin_k1_wrsj_data", tq[256 + 6].wdata, 90);

      run1(24'h000249, 2'd3, 1'b0);
      run1(24'h5A0000, 2'd1, 1'b0);
      run1(24'h000249, 2'd0, 1'b1);
      for (int r = 0; r < 3; r++) run1(24'($urandom), 2'($urandom_range(0, 3)), 1'b0);

      // Abort during WR_SI of i=100: the write lands, engine idles
      launch1(24'h000249, 2'd3);
      repeat (256 + 700 + 5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      q1.delete();
      check("abort_busy", busy1, 0);
      check("abort_done", done1, 0);
      check("abort_wren", wren1, 0);
      check("abort_write", mem1[mj[100]], msi[100]);
      run1(24'h000249, 2'd3, 1'b0);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_done_clear", done1, 0);
      check("abort_done_busy", busy1, 0);

      // Asynchronous reset during WR_SJ of i=50
      launch1(24'h000249, 2'd3);
      repeat (256 + 350 + 6) @(posedge clk);
      #2 check("pre_rst_wren", wren1, 1);
      #1 rst_n = 1'b0;
      q1.delete();
      #1;
      check("arst_wren", wren1, 0);
      check("arst_busy", busy1, 0);
      check("arst_addr", addr1, 0);
      check("arst_wdata", wdata1, 0);
      #8 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_bus", {addr1, wdata1, wren1, busy1, done1}, 0);
      run1(24'h000249, 2'd3, 1'b0);

      // RD_LAT=2, no fill phase, RAM preloaded with identity
      @(posedge clk);
      #1 preload2 = 1'b1;
      key = 24'h000249;
      key_len = 2'd3;
      @(posedge clk);
      #1 preload2 = 1'b0;
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      build(24'h000249, 3, 2, 0);
      q2 = tq;
      cnt = 0;
      do begin
         @(posedge clk);
         #1 cnt++;
      end while (!done2 && cnt < 3000);
      check("latency2", cnt, 2304);
      @(negedge clk);
      for (int a = 0; a < 256; a++) check("s2", mem2[a], ms[a]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
